// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for an in-order pipeline. Keeps the fetch PC and
// issues at most one instruction-memory request at a time. A response is
// either handed straight to the IF/ID register or, while the hazard unit is
// stalling, parked in a one-entry hold buffer until the stall lifts.
// Redirects from later stages override any delivery. A redirect that arrives
// while a request is still in flight sends the FSM to DROP, so the stale
// response is discarded when it comes back.
//
// Parameters
//   RESET_PC       PC loaded on reset
//   NOP_INSTR      instruction presented when nothing valid is delivered
//
// Ports
//   clock          single clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   pc_write       hazard enable; 0 = stall fetch and hold IF/ID
//   redirect_valid taken branch/jump from a later stage
//   redirect_pc    redirect target
//   imem_req       instruction memory request
//   imem_addr      request address (the fetch PC)
//   imem_gnt       request accepted when imem_req & imem_gnt
//   imem_rvalid    response for the single outstanding request
//   imem_rdata     response instruction
//   if_pc          PC toward IF/ID
//   if_instr       instruction toward IF/ID (NOP_INSTR when not valid)
//   if_valid       if_pc/if_instr carry a real instruction
//   if_id_write    IF/ID write enable (follows pc_write)
//   if_id_flush    IF/ID flush (follows redirect_valid)
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pc_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic        if_id_write,
   output logic        if_id_flush
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,  // request pc until granted
      ST_WAIT  = 2'd1,  // request in flight, response pending
      ST_HOLD  = 2'd2,  // response parked in hold buffer during a stall
      ST_DROP  = 2'd3   // request in flight but redirected; discard response
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;

   logic        req_c;
   logic        deliver_c;
   logic [31:0] deliver_word_c;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   // NOTE: the hold buffer is a single data register, so it is cleared on
   // reset like the rest of the state; nothing here is large enough to be a
   // memory that should be left unreset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         hold_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and delivery logic
   // ------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      hold_d         = hold_q;
      req_c          = 1'b0;
      deliver_c      = 1'b0;
      deliver_word_c = NOP_INSTR;

      unique case (state_q)
         ST_FETCH: begin
            req_c = 1'b1;
            if (redirect_valid) begin
               // A grant in the redirect cycle still leaves a response in
               // flight that must be thrown away.
               pc_d    = redirect_pc;
               state_d = imem_gnt ? ST_DROP : ST_FETCH;
            end else if (imem_gnt) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = imem_rvalid ? ST_FETCH : ST_DROP;
            end else if (imem_rvalid) begin
               if (pc_write) begin
                  deliver_c      = 1'b1;
                  deliver_word_c = imem_rdata;
                  pc_d           = pc_q + 32'd4;  // wraps modulo 2^32
                  state_d        = ST_FETCH;
               end else begin
                  hold_d  = imem_rdata;
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = ST_FETCH;
            end else if (pc_write) begin
               deliver_c      = 1'b1;
               deliver_word_c = hold_q;
               pc_d           = pc_q + 32'd4;
               state_d        = ST_FETCH;
            end
         end

         ST_DROP: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            if (imem_rvalid) begin
               state_d = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs. Control outputs are gated by reset so they read as idle for the
   // whole time reset is held, even though the inputs may be active.
   // ------------------------------------------------------------------------
   assign imem_req    = req_c & ~reset;
   assign imem_addr   = pc_q;
   assign if_pc       = pc_q;
   assign if_valid    = deliver_c & ~reset;
   assign if_instr    = (deliver_c & ~reset) ? deliver_word_c : NOP_INSTR;
   assign if_id_write = pc_write & ~reset;
   assign if_id_flush = redirect_valid & ~reset;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Stimulus pushes each expected delivery
// (pc, instruction) into a queue; an independent monitor pops and compares
// whenever the DUT raises if_valid. Control outputs (requests, stalls,
// flushes, reset values) are compared inline against hand-computed values.
// A second instance with RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

   logic        clock = 1'b0;
   logic        reset;
   logic        pc_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        if_id_write;
   logic        if_id_flush;

   // second instance (wrap-around reset PC)
   logic        reset2;
   logic        imem_gnt2;
   logic        imem_rvalid2;
   logic [31:0] imem_rdata2;
   logic        imem_req2;
   logic [31:0] imem_addr2;
   logic [31:0] if_pc2;
   logic [31:0] if_instr2;
   logic        if_valid2;
   logic        if_id_write2;
   logic        if_id_flush2;

   always #5 clock = ~clock;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .pc_write       (pc_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_valid       (if_valid),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clock          (clock),
      .reset          (reset2),
      .pc_write       (1'b1),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0000_0000),
      .imem_req       (imem_req2),
      .imem_addr      (imem_addr2),
      .imem_gnt       (imem_gnt2),
      .imem_rvalid    (imem_rvalid2),
      .imem_rdata     (imem_rdata2),
      .if_pc          (if_pc2),
      .if_instr       (if_instr2),
      .if_valid       (if_valid2),
      .if_id_write    (if_id_write2),
      .if_id_flush    (if_id_flush2)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // memory contents used by the responder: a recognisable tag plus the low
   // address bits, so each expected word can be written down by hand
   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic expect_delivery(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // Zero-wait memory with pc_write=1 for 2*n cycles: grant every request,
   // answer it the next cycle. Called and left at posedge+1.
   task automatic stream(input int n);
      bit          pend = 1'b0;
      logic [31:0] paddr = '0;
      pc_write       = 1'b1;
      redirect_valid = 1'b0;
      for (int c = 0; c < 2 * n; c++) begin
         imem_gnt    = 1'b1;
         imem_rvalid = pend;
         imem_rdata  = pend ? word(paddr) : JUNK;
         @(negedge clock);
         if (imem_req && imem_gnt) begin
            pend  = 1'b1;
            paddr = imem_addr;
         end else begin
            pend = 1'b0;
         end
         next_cycle();
      end
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = JUNK;
   endtask

   // ------------------------------------------------------------------------
   // Delivery monitor / scoreboard
   // ------------------------------------------------------------------------
   always @(negedge clock) begin
      if (!reset && if_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_delivery_pc", if_pc, 32'hXXXX_XXXX);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("deliver_pc", if_pc, e.pc);
            check("deliver_instr", if_instr, e.instr);
         end
      end
   end

   initial begin
      reset          = 1'b1;
      reset2         = 1'b1;
      pc_write       = 1'b1;
      redirect_valid = 1'b1;   // must not leak to if_id_flush during reset
      redirect_pc    = 32'h0000_0500;
      imem_gnt       = 1'b1;
      imem_rvalid    = 1'b1;
      imem_rdata     = JUNK;
      imem_gnt2      = 1'b0;
      imem_rvalid2   = 1'b0;
      imem_rdata2    = JUNK;

      // ---- reset values ----
      @(negedge clock);
      check("rst_imem_req",    imem_req,    0);
      check("rst_if_valid",    if_valid,    0);
      check("rst_if_id_write", if_id_write, 0);
      check("rst_if_id_flush", if_id_flush, 0);
      check("rst_if_instr",    if_instr,    NOP);
      check("rst_if_pc",       if_pc,       32'h0000_0000);
      next_cycle();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;

      // ---- zero-wait streaming: 0x0, 0x4, 0x8 in six cycles ----
      expect_delivery(32'h0000_0000, 32'hC0DE_0000);
      expect_delivery(32'h0000_0004, 32'hC0DE_0004);
      expect_delivery(32'h0000_0008, 32'hC0DE_0008);
      stream(3);
      check("stream_all_delivered", exp_q.size(), 0);
      @(negedge clock);
      check("stream_next_addr", imem_addr, 32'h0000_000C);
      next_cycle();

      // ---- reset from FETCH, then stream 0x0, 0x4 ----
      reset = 1'b1;
      @(negedge clock);
      check("rst2_if_pc", if_pc, 32'h0000_0000);
      next_cycle();
      reset = 1'b0;
      expect_delivery(32'h0000_0000, 32'hC0DE_0000);
      expect_delivery(32'h0000_0004, 32'hC0DE_0004);
      stream(2);

      // ---- stall with response at 0x8 ----
      imem_gnt = 1'b1;
      @(negedge clock);
      check("hold_req_addr", imem_addr, 32'h0000_0008);
      next_cycle();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(32'h8); pc_write = 1'b0;
      @(negedge clock);
      check("hold_cap_valid", if_valid,    0);
      check("hold_cap_instr", if_instr,    NOP);
      check("hold_cap_write", if_id_write, 0);
      check("hold_cap_req",   imem_req,    0);
      next_cycle();
      imem_rvalid = 1'b0; imem_rdata = JUNK;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         check("hold_stall_req",   imem_req,    0);
         check("hold_stall_write", if_id_write, 0);
         check("hold_stall_valid", if_valid,    0);
         next_cycle();
      end
      pc_write = 1'b1;
      expect_delivery(32'h0000_0008, 32'hC0DE_0008);
      @(negedge clock);
      check("hold_release_valid", if_valid, 1);
      next_cycle();
      imem_gnt = 1'b1;
      @(negedge clock);
      check("after_hold_req",  imem_req,  1);
      check("after_hold_addr", imem_addr, 32'h0000_000C);
      next_cycle();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(32'hC);
      expect_delivery(32'h0000_000C, 32'hC0DE_000C);
      next_cycle();

      // ---- redirect coincident with rvalid for 0x10 ----
      imem_rvalid = 1'b0; imem_rdata = JUNK; imem_gnt = 1'b1;
      @(negedge clock);
      check("req_0x10_addr", imem_addr, 32'h0000_0010);
      next_cycle();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(32'h10);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      @(negedge clock);
      check("redir_rv_flush", if_id_flush, 1);
      check("redir_rv_valid", if_valid,    0);
      check("redir_rv_instr", if_instr,    NOP);
      next_cycle();
      imem_rvalid = 1'b0; imem_rdata = JUNK; redirect_valid = 1'b0; imem_gnt = 1'b1;
      @(negedge clock);
      check("redir_rv_req",  imem_req,  1);
      check("redir_rv_addr", imem_addr, 32'h0000_0100);
      next_cycle();

      // ---- redirect while in WAIT, response two cycles later ----
      imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      @(negedge clock);
      check("redir_wait_flush", if_id_flush, 1);
      check("redir_wait_valid", if_valid,    0);
      next_cycle();
      redirect_valid = 1'b0;
      @(negedge clock);
      check("drop_idle_req", imem_req, 0);
      next_cycle();
      imem_rvalid = 1'b1; imem_rdata = word(32'h100);
      @(negedge clock);
      check("drop_rv_valid", if_valid, 0);
      check("drop_rv_req",   imem_req, 0);
      next_cycle();
      imem_rvalid = 1'b0; imem_rdata = JUNK;
      @(negedge clock);
      check("after_drop_req",  imem_req,  1);
      check("after_drop_addr", imem_addr, 32'h0000_0200);
      next_cycle();
      expect_delivery(32'h0000_0200, 32'hC0DE_0200);
      stream(1);

      // ---- redirect in FETCH together with grant ----
      imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      @(negedge clock);
      check("redir_gnt_addr",  imem_addr,   32'h0000_0204);
      check("redir_gnt_flush", if_id_flush, 1);
      next_cycle();
      imem_gnt = 1'b0; redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(32'h204);
      @(negedge clock);
      check("redir_gnt_drop_valid", if_valid, 0);
      next_cycle();
      imem_rvalid = 1'b0; imem_rdata = JUNK; imem_gnt = 1'b1;
      @(negedge clock);
      check("redir_gnt_next_addr", imem_addr, 32'h0000_0300);
      next_cycle();

      // ---- redirect while holding ----
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(32'h300); pc_write = 1'b0;
      next_cycle();
      imem_rvalid = 1'b0; imem_rdata = JUNK; pc_write = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
      @(negedge clock);
      check("redir_hold_valid", if_valid,    0);
      check("redir_hold_flush", if_id_flush, 1);
      next_cycle();
      redirect_valid = 1'b0; imem_gnt = 1'b1;
      @(negedge clock);
      check("redir_hold_addr", imem_addr, 32'h0000_0400);
      check("redir_hold_req",  imem_req,  1);
      next_cycle();

      // ---- reset pulsed while in WAIT, stale rvalid afterwards ----
      imem_gnt = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      check("rstw_req",   imem_req,    0);
      check("rstw_pc",    if_pc,       32'h0000_0000);
      check("rstw_valid", if_valid,    0);
      check("rstw_write", if_id_write, 0);
      check("rstw_instr", if_instr,    NOP);
      next_cycle();
      reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = word(32'h400);
      @(negedge clock);
      check("stale_rv_valid", if_valid,  0);
      check("stale_rv_req",   imem_req,  1);
      check("stale_rv_addr",  imem_addr, 32'h0000_0000);
      next_cycle();
      imem_rvalid = 1'b0; imem_rdata = JUNK;
      @(negedge clock);
      check("post_rst_addr", imem_addr, 32'h0000_0000);
      next_cycle();
      expect_delivery(32'h0000_0000, 32'hC0DE_0000);
      stream(1);

      // ---- wrap-around instance ----
      reset2 = 1'b0; imem_gnt2 = 1'b1;
      @(negedge clock);
      check("wrap_req",  imem_req2,  1);
      check("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
      next_cycle();
      imem_gnt2 = 1'b0; imem_rvalid2 = 1'b1; imem_rdata2 = 32'h1111_2222;
      @(negedge clock);
      check("wrap_valid", if_valid2, 1);
      check("wrap_pc",    if_pc2,    32'hFFFF_FFFC);
      check("wrap_instr", if_instr2, 32'h1111_2222);
      next_cycle();
      imem_rvalid2 = 1'b0; imem_rdata2 = JUNK;
      @(negedge clock);
      check("wrap_next_req",  imem_req2,  1);
      check("wrap_next_addr", imem_addr2, 32'h0000_0000);
      next_cycle();

      next_cycle();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter: NOP_INSTR, 32'h0000_0013, instruction driven when no valid fetch is delivered.
REQ-003 SHALL have port: clock  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: pc_write  in  1  hazard unit enable; 0 = stall fetch and hold the IF/ID register.
REQ-006 SHALL have port: redirect_valid  in  1  taken branch/jump from a later stage.
REQ-007 SHALL have port: redirect_pc  in  32  redirect target.
REQ-008 SHALL have port: imem_req  out  1  instruction memory request.
REQ-009 SHALL have port: imem_addr  out  32  request address.
REQ-010 SHALL have port: imem_gnt  in  1  request accepted when imem_req&imem_gnt.
REQ-011 SHALL have port: imem_rvalid  in  1  response for the single outstanding request.
REQ-012 SHALL have port: imem_rdata  in  32  response instruction.
REQ-013 SHALL have ports: if_pc  out  32 and if_instr  out  32, data toward the IF/ID register.
REQ-014 SHALL have port: if_valid  out  1  1 = if_pc/if_instr carry a real instruction.
REQ-015 SHALL have ports: if_id_write  out  1 and if_id_flush  out  1, IF/ID register controls.

Function
REQ-016 SHALL keep a 32-bit fetch PC, a 32-bit hold buffer and a state in {FETCH, WAIT, HOLD, DROP}.
REQ-017 SHALL allow at most one outstanding imem request; the memory does not require the request address to stay stable before grant.
REQ-018 FETCH: imem_req=1 and imem_addr=pc; on imem_gnt go to WAIT. Otherwise stay in FETCH.
REQ-019 WAIT: imem_req=0. On imem_rvalid with pc_write=1, deliver imem_rdata, set pc<=pc+4 and go to FETCH.
REQ-020 WAIT: on imem_rvalid with pc_write=0, capture imem_rdata into the hold buffer and go to HOLD.
REQ-021 HOLD: imem_req=0. When pc_write=1, deliver the hold buffer, set pc<=pc+4 and go to FETCH.
REQ-022 Deliver SHALL mean, combinationally in that cycle: if_valid=1, if_pc=pc, and if_instr = the delivered word.
REQ-023 When not delivering, outputs SHALL be if_valid=0, if_instr=NOP_INSTR and if_pc=pc.
REQ-024 if_id_write SHALL equal pc_write (stall holds IF/ID; an undelivered cycle writes a bubble).
REQ-025 if_id_flush SHALL equal redirect_valid; redirect has priority over every delivery, and if_valid SHALL be 0 in a redirect cycle.
REQ-026 Redirect in FETCH without grant: pc<=redirect_pc and stay in FETCH.
REQ-027 Redirect in FETCH with grant: pc<=redirect_pc and go to DROP.
REQ-028 Redirect in WAIT without imem_rvalid: pc<=redirect_pc and go to DROP.
REQ-029 Redirect in WAIT with imem_rvalid: discard the response, pc<=redirect_pc, go to FETCH.
REQ-030 Redirect in HOLD: discard the hold buffer, pc<=redirect_pc, go to FETCH.
REQ-031 DROP: imem_req=0 and nothing is delivered. On imem_rvalid, discard the response and go to FETCH. A further redirect in DROP only updates pc.
REQ-032 Redirect SHALL act regardless of pc_write.
REQ-033 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-034 Fetch-to-deliver latency SHALL be one cycle from grant at minimum (zero-wait memory: grant at cycle N, rvalid at N+1, deliver at N+1). Sustained throughput is one instruction per 2 cycles.

Reset
REQ-035 While reset=1, outputs SHALL be: pc=RESET_PC, state=FETCH, hold buffer=0, imem_req=0, if_valid=0, if_id_write=0, if_id_flush=0, if_instr=NOP_INSTR.
REQ-036 Reset asserted mid-request SHALL abandon the request. After release, the first imem_req SHALL be to RESET_PC.

Verification
REQ-037 Zero-wait memory, pc_write=1 -> deliveries with if_pc 0x0, 0x4, 0x8, one every 2 cycles, if_instr=imem_rdata.
REQ-038 rvalid at PC 0x8 with pc_write=0 for 3 cycles -> state HOLD, if_id_write=0, no imem_req. On pc_write=1, deliver 0x8 with the held word, then request 0xC.
REQ-039 Redirect to 0x100 in the same cycle as rvalid for 0x10 -> if_id_flush=1, if_valid=0, next imem_addr=0x100.
REQ-040 Redirect to 0x200 while in WAIT, rvalid two cycles later -> response dropped, nothing delivered, next request 0x200.
REQ-041 RESET_PC=32'hFFFF_FFFC -> first delivery at 0xFFFF_FFFC, next request at 0x0000_0000.
REQ-042 Reset pulsed while in WAIT -> all outputs at reset values immediately; after release, a request to RESET_PC; a stale rvalid after release with no grant given is ignored.
